// File: rtl/char_mem_pkg.sv
// rtl/char_mem_pkg.sv - shared screen geometry, widths and arbiter state encoding
package char_mem_pkg;

   localparam int COLS   = 80;
   localparam int ROWS   = 40;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

   // Control codes the UART writer interprets before addressing the RAM
   localparam logic [DATA_W-1:0] CHAR_CR  = 8'd13;
   localparam logic [DATA_W-1:0] CHAR_ESC = 8'd27;
   localparam logic [DATA_W-1:0] CHAR_DEL = 8'd127;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2
   } arb_state_t;

endpackage

// File: rtl/char_mem_arbiter_if.sv
// rtl/char_mem_arbiter_if.sv - writer ports, fill control and RAM write port bundle
interface char_mem_arbiter_if;
   import char_mem_pkg::*;

   logic              req_a;
   logic              req_b;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] data_b;
   logic              ack_a;
   logic              ack_b;
   logic              addr_err;
   logic              clear_req;
   logic              clear_busy;
   logic              clear_done;
   logic [ADDR_W-1:0] mem_wraddress;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;

   modport master (
      output req_a, req_b, addr_a, addr_b, data_a, data_b, clear_req,
      input  ack_a, ack_b, addr_err, clear_busy, clear_done,
             mem_wraddress, mem_data, mem_wren
   );

   modport slave (
      input  req_a, req_b, addr_a, addr_b, data_a, data_b, clear_req,
      output ack_a, ack_b, addr_err, clear_busy, clear_done,
             mem_wraddress, mem_data, mem_wren
   );

endinterface

// File: rtl/char_mem_arbiter_rr_arb2.sv
// rtl/char_mem_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant memory
module rr_arb2 (
   input  logic       clock100,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       last_grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // last_grant = 1 means port B; reset there so port A wins the first tie
   always_ff @(posedge clock100 or posedge reset) begin
      if (reset)
         last_grant <= 1'b1;
      else if (advance && (|grant))
         last_grant <= grant[1];
   end

endmodule

// File: rtl/char_mem_arbiter.sv
// rtl/char_mem_arbiter.sv - character RAM write-port arbiter with full-screen fill engine
module char_mem_arbiter
   import char_mem_pkg::*;
#(
   parameter logic [DATA_W-1:0] FILL_CHAR = 8'd0
) (
   input  logic             clock100,
   input  logic             reset,
   char_mem_arbiter_if.slave bus
);

   arb_state_t        state, state_next;
   logic [ADDR_W-1:0] fill_cnt, fill_cnt_next;
   logic [1:0]        grant;
   logic              last_grant;
   logic              advance;

   logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
   logic [DATA_W-1:0] wr_data_q, wr_data_n;
   logic              wren_q, wren_n;
   logic              err_q, err_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   rr_arb2 u_rr_arb2 (
      .clock100   (clock100),
      .reset      (reset),
      .req        ({bus.req_b, bus.req_a}),
      .advance    (advance),
      .grant      (grant),
      .last_grant (last_grant)
   );

   assign sel_addr = grant[1] ? bus.addr_b : bus.addr_a;
   assign sel_data = grant[1] ? bus.data_b : bus.data_a;

   always_comb begin
      state_next    = state;
      fill_cnt_next = fill_cnt;
      advance       = 1'b0;
      wr_addr_n     = wr_addr_q;
      wr_data_n     = wr_data_q;
      wren_n        = 1'b0;
      err_n         = 1'b0;
      busy_n        = 1'b0;
      done_n        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clear_req) begin
               state_next = CLEAR;
               wren_n     = 1'b1;
               wr_addr_n  = '0;
               wr_data_n  = FILL_CHAR;
               busy_n     = 1'b1;
            end else if (|grant) begin
               state_next = WRITE;
               advance    = 1'b1;
               wr_addr_n  = sel_addr;
               wr_data_n  = sel_data;
               if (sel_addr < CELLS_A)
                  wren_n = 1'b1;
               else
                  err_n = 1'b1;
            end
         end
         WRITE: state_next = IDLE;
         CLEAR: begin
            // The clear_done cycle is the final CLEAR cycle, so a waiting writer
            // is sampled in the IDLE cycle after it and lands two cycles later.
            if (done_q) begin
               state_next = IDLE;
            end else if (fill_cnt == LAST_CELL) begin
               fill_cnt_next = '0;
               done_n        = 1'b1;
            end else begin
               fill_cnt_next = fill_cnt + ADDR_W'(1);
               wr_addr_n     = fill_cnt + ADDR_W'(1);
               wr_data_n     = FILL_CHAR;
               wren_n        = 1'b1;
               busy_n        = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock100 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fill_cnt  <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wren_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_next;
         fill_cnt  <= fill_cnt_next;
         wr_addr_q <= wr_addr_n;
         wr_data_q <= wr_data_n;
         wren_q    <= wren_n;
         err_q     <= err_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   // last_grant already names the port granted on entry to WRITE
   assign bus.ack_a         = (state == WRITE) && !last_grant;
   assign bus.ack_b         = (state == WRITE) && last_grant;
   assign bus.addr_err      = err_q;
   assign bus.clear_busy    = busy_q;
   assign bus.clear_done    = done_q;
   assign bus.mem_wraddress = wr_addr_q;
   assign bus.mem_data      = wr_data_q;
   assign bus.mem_wren      = wren_q;

endmodule

// File: tb/tb_char_mem_arbiter.sv
// tb/tb_char_mem_arbiter.sv - directed self-checking bench for char_mem_arbiter
module tb_char_mem_arbiter;
   import char_mem_pkg::*;

   localparam logic [DATA_W-1:0] FILL = 8'h20;

   logic clock100 = 1'b0;
   logic reset    = 1'b1;
   int   total    = 0;
   int   bad      = 0;

   always #5 clock100 = ~clock100;

   char_mem_arbiter_if bus ();

   char_mem_arbiter #(.FILL_CHAR(FILL)) dut (
      .clock100 (clock100),
      .reset    (reset),
      .bus      (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock100);
   endtask

   task automatic idle_inputs();
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      bus.addr_a = '0;  bus.addr_b = '0;
      bus.data_a = '0;  bus.data_b = '0;
      bus.clear_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      int v;
      v = 32'(bus.mem_wren) + 32'(bus.ack_a) + 32'(bus.ack_b) + 32'(bus.addr_err)
        + 32'(bus.clear_busy) + 32'(bus.clear_done) + 32'(bus.mem_wraddress) + 32'(bus.mem_data);
      check_eq(tag, 32'(v), 32'd0);
   endtask

   // Full fill from an IDLE start; optionally raise req_b at fill index b_at
   task automatic do_fill(input int b_at);
      int nerr;
      int nack;
      nerr = 0;
      nack = 0;
      bus.clear_req = 1'b1;
      for (int j = 0; j < CELLS; j++) begin
         tick();
         if (j == 0) bus.clear_req = 1'b0;
         if (!bus.mem_wren || 32'(bus.mem_wraddress) != j || bus.mem_data != FILL
             || !bus.clear_busy || bus.clear_done) nerr++;
         if (bus.ack_a || bus.ack_b) nack++;
         if (j == b_at) begin
            bus.req_b = 1'b1; bus.addr_b = 12'd500; bus.data_b = 8'h55;
         end
      end
      check_eq("fill_writes_bad", 32'(nerr), 32'd0);
      check_eq("fill_acks", 32'(nack), 32'd0);
      tick();
      check_eq("fill_done", 32'(bus.clear_done), 32'd1);
      check_eq("fill_busy_low", 32'(bus.clear_busy), 32'd0);
      check_eq("fill_wren_low", 32'(bus.mem_wren), 32'd0);
      check_eq("fill_done_ackb", 32'(bus.ack_b), 32'd0);
      tick();
      check_eq("fill_done_once", 32'(bus.clear_done), 32'd0);
      check_eq("post_fill_wren", 32'(bus.mem_wren), 32'd0);
      check_eq("post_fill_ackb", 32'(bus.ack_b), 32'd0);
      if (b_at >= 0) begin
         tick();
         check_eq("b_after_fill_ack", 32'(bus.ack_b), 32'd1);
         check_eq("b_after_fill_wren", 32'(bus.mem_wren), 32'd1);
         check_eq("b_after_fill_addr", 32'(bus.mem_wraddress), 32'd500);
         check_eq("b_after_fill_data", 32'(bus.mem_data), 32'h55);
         bus.req_b = 1'b0;
         tick();
         check_eq("b_after_fill_single", 32'(bus.ack_b), 32'd0);
      end else begin
         tick();
         check_eq("idle_after_fill", 32'(bus.mem_wren) + 32'(bus.clear_busy), 32'd0);
      end
   endtask

   initial begin
      bit found;
      idle_inputs();
      repeat (3) tick();
      check_all_zero("reset_outputs");
      reset = 1'b0;
      tick();

      // single port A write
      bus.req_a = 1'b1; bus.addr_a = 12'd81; bus.data_a = 8'h41;
      tick();
      check_eq("a_wren", 32'(bus.mem_wren), 32'd1);
      check_eq("a_addr", 32'(bus.mem_wraddress), 32'd81);
      check_eq("a_data", 32'(bus.mem_data), 32'h41);
      check_eq("a_ack", 32'(bus.ack_a), 32'd1);
      check_eq("a_no_ackb", 32'(bus.ack_b), 32'd0);
      check_eq("a_no_err", 32'(bus.addr_err), 32'd0);
      bus.req_a = 1'b0;
      tick();
      check_eq("a_wren_one_cycle", 32'(bus.mem_wren), 32'd0);
      check_eq("a_ack_one_cycle", 32'(bus.ack_a), 32'd0);

      // both ports saturated from reset: A,B,A,B...
      reset = 1'b1; tick(); reset = 1'b0; tick();
      bus.req_a = 1'b1; bus.addr_a = 12'd10; bus.data_a = 8'hA0;
      bus.req_b = 1'b1; bus.addr_b = 12'd20; bus.data_b = 8'hB0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i % 2 == 0) begin
            check_eq($sformatf("rr%0d_ack_a", i / 2), 32'(bus.ack_a), 32'((i / 2) % 2 == 0));
            check_eq($sformatf("rr%0d_ack_b", i / 2), 32'(bus.ack_b), 32'((i / 2) % 2 == 1));
            check_eq($sformatf("rr%0d_addr", i / 2), 32'(bus.mem_wraddress),
                     ((i / 2) % 2 == 0) ? 32'd10 : 32'd20);
            check_eq($sformatf("rr%0d_wren", i / 2), 32'(bus.mem_wren), 32'd1);
         end else begin
            check_eq($sformatf("rr%0d_gap", i / 2), 32'(bus.mem_wren), 32'd0);
         end
      end
      idle_inputs();
      tick();

      do_fill(-1);
      do_fill(100);

      // out-of-range address is acked and dropped, last cell is written
      bus.req_a = 1'b1; bus.addr_a = 12'd3200; bus.data_a = 8'h77;
      tick();
      check_eq("oor_ack", 32'(bus.ack_a), 32'd1);
      check_eq("oor_err", 32'(bus.addr_err), 32'd1);
      check_eq("oor_wren", 32'(bus.mem_wren), 32'd0);
      bus.addr_a = 12'd3199; bus.data_a = 8'h78;
      tick();
      check_eq("oor_err_pulse", 32'(bus.addr_err), 32'd0);
      tick();
      check_eq("last_ack", 32'(bus.ack_a), 32'd1);
      check_eq("last_wren", 32'(bus.mem_wren), 32'd1);
      check_eq("last_addr", 32'(bus.mem_wraddress), 32'd3199);
      check_eq("last_data", 32'(bus.mem_data), 32'h78);
      check_eq("last_err", 32'(bus.addr_err), 32'd0);
      idle_inputs();
      tick();

      // reset in the middle of a fill
      found = 1'b0;
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (bus.mem_wren && 32'(bus.mem_wraddress) == 1500) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check_eq("reach_1500", 32'(found), 32'd1);
      reset = 1'b1;
      #1;
      check_all_zero("async_reset_outputs");
      repeat (5) tick();
      reset = 1'b0;
      begin
         int act;
         act = 0;
         for (int k = 0; k < 10; k++) begin
            tick();
            act += 32'(bus.clear_done) + 32'(bus.mem_wren) + 32'(bus.clear_busy);
         end
         check_eq("abandoned_fill_quiet", 32'(act), 32'd0);
      end
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      check_eq("refill_wren", 32'(bus.mem_wren), 32'd1);
      check_eq("refill_addr0", 32'(bus.mem_wraddress), 32'd0);
      check_eq("refill_busy", 32'(bus.clear_busy), 32'd1);
      tick();
      check_eq("refill_addr1", 32'(bus.mem_wraddress), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
